// File: rtl/sq_div.sv
// sq_div: sequential restoring (shift/subtract) integer divider.
// One quotient bit per clock. The operation starts when reset is released.
// The result is held, with op_done set, until the next reset.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high; deassertion starts an operation
//   div0     - dividend, held stable from reset high until op_done
//   div1     - divisor, held stable from reset high until op_done
//   op       - 3 uquot, 4 urem, 5 squot (trunc to zero), 6 srem (sign of dividend)
//   out      - result, zero while op_done is low
//   op_done  - result-valid flag, sticky until reset
module sq_div #(
    parameter int unsigned op_sz = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [op_sz-1:0] div0,
    input  logic [op_sz-1:0] div1,
    input  logic [3:0]       op,
    output logic [op_sz-1:0] out,
    output logic             op_done
);

    localparam int unsigned CW = $clog2(op_sz + 1);

    localparam logic [3:0] OP_UQUO = 4'd3;
    localparam logic [3:0] OP_UREM = 4'd4;
    localparam logic [3:0] OP_SQUO = 4'd5;
    localparam logic [3:0] OP_SREM = 4'd6;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [op_sz-1:0] quo_q, quo_d;   // dividend shifts out of the top, quotient bits enter at the bottom
    logic [op_sz-1:0] rem_q, rem_d;
    logic [op_sz-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [op_sz-1:0] out_q, out_d;
    logic             done_q, done_d;

    logic [op_sz:0]   shifted;
    logic [op_sz:0]   diff;
    logic [op_sz-1:0] abs0, abs1;
    logic [op_sz-1:0] quo_fin, rem_fin;
    logic             is_signed, is_valid;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            op_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        out_d   = out_q;
        done_d  = done_q;

        is_signed = (op == OP_SQUO) || (op == OP_SREM);
        is_valid  = (op == OP_UQUO) || (op == OP_UREM) || is_signed;

        // Magnitudes; the most-negative value maps to its unsigned op_sz-bit magnitude
        abs0 = div0[op_sz-1] ? (~div0 + op_sz'(1)) : div0;
        abs1 = div1[op_sz-1] ? (~div1 + op_sz'(1)) : div1;

        // rem < divisor always holds, so bit op_sz of the difference is the borrow
        shifted = {rem_q, quo_q[op_sz-1]};
        diff    = shifted - {1'b0, dvs_q};

        quo_fin = negq_q ? (~quo_q + op_sz'(1)) : quo_q;
        rem_fin = negr_q ? (~rem_q + op_sz'(1)) : rem_q;

        case (state_q)
            LOAD: begin
                op_d  = op;
                rem_d = '0;
                cnt_d = CW'(op_sz);
                if (is_signed) begin
                    quo_d  = abs0;
                    dvs_d  = abs1;
                    negq_d = div0[op_sz-1] ^ div1[op_sz-1];
                    negr_d = div0[op_sz-1];
                end else begin
                    quo_d  = div0;
                    dvs_d  = div1;
                    negq_d = 1'b0;
                    negr_d = 1'b0;
                end
                if (!is_valid) begin
                    state_d = DONE;
                    quo_d   = '0;
                    rem_d   = '0;
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                end else if (div1 == '0) begin
                    // Divide by zero: all-ones quotient, untouched dividend as remainder
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = div0;
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = diff[op_sz] ? shifted[op_sz-1:0] : diff[op_sz-1:0];
                quo_d = {quo_q[op_sz-2:0], ~diff[op_sz]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result is registered once on entry, then held until reset
                if (!done_q) begin
                    done_d = 1'b1;
                    case (op_q)
                        OP_UQUO, OP_SQUO: out_d = quo_fin;
                        OP_UREM, OP_SREM: out_d = rem_fin;
                        default:          out_d = '0;
                    endcase
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign out     = out_q;
    assign op_done = done_q;

endmodule

// File: tb/tb_sq_div.sv
// tb_sq_div: scoreboard bench for sq_div (op_sz = 32).
module tb_sq_div;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] div0;
    logic [W-1:0] div1;
    logic [3:0]   op;
    logic [W-1:0] out;
    logic         op_done;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [W-1:0] val;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    sq_div #(.op_sz(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .div0    (div0),
        .div1    (div1),
        .op      (op),
        .out     (out),
        .op_done (op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Reference model: plain SV arithmetic with the corner cases spelled out
    function automatic logic [W-1:0] model_out(input logic [3:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0]        ones;
        sa   = a;
        sb   = b;
        ones = '1;
        case (o)
            4'd3: return (b == 0) ? ones : a / b;
            4'd4: return (b == 0) ? a : a % b;
            4'd5: begin
                if (b == 0)         return ones;
                else if (b == ones) return W'(0) - a;
                else                return W'(sa / sb);
            end
            4'd6: begin
                if (b == 0)         return a;
                else if (b == ones) return W'(0);
                else                return W'(sa % sb);
            end
            default: return W'(0);
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [W-1:0] b);
        if (o < 4'd3 || o > 4'd6 || b == 0) return 2;
        return W + 2;
    endfunction

    // One operation: push expectation, pulse reset, wait for op_done, pop and compare
    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit tog);
        exp_t         e;
        exp_t         g;
        bit           seen;
        bit           pre_bad;
        int           lat;
        logic [W-1:0] held;
        e.val = model_out(o, a, b);
        e.lat = model_lat(o, b);
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b1;
        op    = o;
        div0  = a;
        div1  = b;
        @(negedge clk);
        reset   = 1'b0;
        seen    = 1'b0;
        pre_bad = 1'b0;
        lat     = 0;
        for (int c = 1; c <= int'(W) + 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (tog && c == 1) begin
                div0 = $urandom;
                div1 = $urandom;
                op   = 4'($urandom);
            end
            if (op_done) begin
                seen = 1'b1;
                lat  = c;
            end else if (out !== '0) begin
                pre_bad = 1'b1;
            end
        end
        check({tag, "_zero_before_done"}, W'(pre_bad), W'(0));
        if (!seen) begin
            check({tag, "_timeout"}, W'(0), W'(1));
            void'(exp_q.pop_front());
        end else begin
            g = exp_q.pop_front();
            check({tag, "_latency"}, W'(lat), W'(g.lat));
            check({tag, "_out"}, out, g.val);
        end
        if (tog) begin
            held = out;
            for (int k = 0; k < 3; k++) begin
                div0 = $urandom;
                div1 = $urandom;
                op   = 4'($urandom);
                @(posedge clk);
                #1;
            end
            check({tag, "_held_out"}, out, held);
            check({tag, "_held_done"}, W'(op_done), W'(1));
        end
    endtask

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        op       = 4'd0;
        div0     = '0;
        div1     = '0;
        #12;
        check("reset_out", out, W'(0));
        check("reset_done", W'(op_done), W'(0));

        // Basic and back-to-back sequencer pattern
        do_op("u_q_20_4", 4'd3, 32'd20, 32'd4, 1'b0);
        do_op("u_r_20_4", 4'd4, 32'd20, 32'd4, 1'b0);
        do_op("u_q_600_7", 4'd3, 32'd600, 32'd7, 1'b0);
        do_op("u_r_600_7", 4'd4, 32'd600, 32'd7, 1'b0);
        do_op("u_q_420_600", 4'd3, 32'd420, 32'd600, 1'b0);
        do_op("u_r_420_600", 4'd4, 32'd420, 32'd600, 1'b0);

        // Signed
        do_op("s_q_m7_2", 4'd5, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("s_r_m7_2", 4'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("s_q_7_m2", 4'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op("s_r_7_m2", 4'd6, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // Divide by zero, signed overflow, most-negative by positive
        do_op("u_q_div0", 4'd3, 32'd9, 32'd0, 1'b0);
        do_op("u_r_div0", 4'd4, 32'd9, 32'd0, 1'b0);
        do_op("s_q_div0", 4'd5, 32'hFFFF_FFF0, 32'd0, 1'b0);
        do_op("s_q_ovf", 4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("s_r_ovf", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("s_q_minneg_3", 4'd5, 32'h8000_0000, 32'd3, 1'b0);
        do_op("u_q_max_1", 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Invalid ops
        do_op("inv_op2", 4'd2, 32'd100, 32'd3, 1'b0);
        do_op("inv_op15", 4'd15, 32'd100, 32'd3, 1'b0);

        // Async reset while holding a result in DONE
        do_op("pre_abort", 4'd3, 32'd600, 32'd7, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_done_out", out, W'(0));
        check("abort_done_flag", W'(op_done), W'(0));

        // Async reset mid-run, then a fresh operation
        @(negedge clk);
        reset = 1'b0;
        op    = 4'd3;
        div0  = 32'd600;
        div1  = 32'd7;
        for (int c = 0; c < 10; c++) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_run_out", out, W'(0));
        check("abort_run_flag", W'(op_done), W'(0));
        do_op("after_abort", 4'd3, 32'd5, 32'd9, 1'b0);

        // Input changes during RUN and DONE are ignored
        do_op("toggle_q", 4'd3, 32'd600, 32'd7, 1'b1);
        do_op("toggle_sr", 4'd6, 32'hFFFF_FC00, 32'd7, 1'b1);

        // Random operations
        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(2, 7));
            ra = $urandom;
            if (i % 7 == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 20));
                2:       rb = $urandom;
                default: rb = W'(0) - W'($urandom_range(1, 20));
            endcase
            do_op("rand", ro, ra, rb, 1'b0);
        end

        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
